// File: rtl/pe_packet_injector_pkg.sv
// Shared constants and types for the PE-side packet injector: flit geometry,
// header tag/field positions and the injector FSM encoding.
package pe_packet_injector_pkg;

  localparam int FLIT_WIDTH   = 32;
  localparam int PACKET_FLITS = 5;
  localparam int BUFFER_DEPTH = 4;
  localparam int COUNT_WIDTH  = 16;

  localparam logic [1:0] HDR_TAG      = 2'b10;
  localparam int         HDR_TAG_LSB  = 30;
  localparam int         HDR_X_LSB    = 27;
  localparam int         HDR_Y_LSB    = 24;
  localparam int         HDR_XY_WIDTH = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } inj_state_e;

endpackage

// File: rtl/pe_packet_injector_credit_counter.sv
// Credit-based flow-control counter: starts full, counts down per flit sent and
// up per returned credit, saturating at DEPTH with a sticky overflow flag.
module credit_counter #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_consume,
  input  logic i_credit,
  output logic o_has_credit,
  output logic o_error
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] r_credits;
  logic          r_error;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= FULL;
      r_error   <= 1'b0;
    end else begin
      unique case ({i_consume, i_credit})
        2'b10: if (r_credits != '0) r_credits <= r_credits - 1'b1;
        2'b01: begin
          // A credit at full count means the router returned one it never owed.
          if (r_credits == FULL) r_error   <= 1'b1;
          else                   r_credits <= r_credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_has_credit = (r_credits != '0);
  assign o_error      = r_error;

endmodule

// File: rtl/pe_packet_injector.sv
// PE transmit stage: captures a whole packet in one handshake, tags the header
// and serialises it onto the router input channel under credit flow control.
module pe_packet_injector #(
  parameter int FLIT_WIDTH   = pe_packet_injector_pkg::FLIT_WIDTH,
  parameter int PACKET_FLITS = pe_packet_injector_pkg::PACKET_FLITS,
  parameter int BUFFER_DEPTH = pe_packet_injector_pkg::BUFFER_DEPTH,
  parameter int COUNT_WIDTH  = pe_packet_injector_pkg::COUNT_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [FLIT_WIDTH*PACKET_FLITS-1:0] pe_packet_din,
  input  logic                               pe_packet_valid,
  output logic                               pe_packet_ready,
  output logic [FLIT_WIDTH-1:0]              channel_dout,
  output logic                               channel_valid_dout,
  input  logic                               channel_credit_din,
  output logic [COUNT_WIDTH-1:0]             packet_count,
  output logic                               credit_error
);

  import pe_packet_injector_pkg::*;

  localparam int               IDX_W    = $clog2(PACKET_FLITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_FLITS - 1);

  inj_state_e r_state, w_state_next;

  logic [PACKET_FLITS-1:0][FLIT_WIDTH-1:0] r_packet;
  logic [IDX_W-1:0]       r_flit_index;
  logic                   r_ready;
  logic                   r_valid;
  logic [FLIT_WIDTH-1:0]  r_dout;
  logic [COUNT_WIDTH-1:0] r_count;

  logic                  w_accept;
  logic                  w_send;
  logic                  w_last;
  logic                  w_has_credit;
  logic                  w_credit_error;
  logic [FLIT_WIDTH-1:0] w_header;

  // NOTE: every combinational output gets a default first so no path can
  // infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_send       = 1'b0;
    w_last       = (r_flit_index == LAST_IDX);
    w_header     = pe_packet_din[FLIT_WIDTH-1:0];
    w_header[HDR_TAG_LSB +: 2] = HDR_TAG;
    unique case (r_state)
      ST_IDLE: begin
        w_accept = pe_packet_valid && r_ready;
        if (w_accept) w_state_next = ST_SEND;
      end
      ST_SEND: begin
        // Decision uses the registered credit count; a credit arriving this
        // cycle only helps next cycle.
        w_send = w_has_credit;
        if (w_send && w_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready      <= 1'b1;
      r_valid      <= 1'b0;
      r_dout       <= '0;
      r_flit_index <= '0;
      r_count      <= '0;
    end else begin
      r_ready <= (w_state_next == ST_IDLE);
      r_valid <= w_send;
      if (w_send) r_dout <= r_packet[r_flit_index];
      if (w_accept)    r_flit_index <= '0;
      else if (w_send) r_flit_index <= w_last ? '0 : r_flit_index + 1'b1;
      if (w_send && w_last) r_count <= r_count + 1'b1;
    end
  end

  // NOTE: the holding register is pure data, always written before it is read,
  // so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_packet <= {pe_packet_din[FLIT_WIDTH*PACKET_FLITS-1:FLIT_WIDTH], w_header};
  end

  credit_counter #(
    .DEPTH(BUFFER_DEPTH)
  ) u_credit_counter (
    .clk          (clk),
    .rst          (reset),
    .i_consume    (w_send),
    .i_credit     (channel_credit_din),
    .o_has_credit (w_has_credit),
    .o_error      (w_credit_error)
  );

  assign pe_packet_ready    = r_ready;
  assign channel_dout       = r_dout;
  assign channel_valid_dout = r_valid;
  assign packet_count       = r_count;
  assign credit_error       = w_credit_error;

endmodule

// File: tb/tb_pe_packet_injector.sv
// Scoreboard bench for pe_packet_injector: a router-side model returns credits,
// a monitor pops expected flits as the channel presents them.
module tb_pe_packet_injector;

  localparam int FW  = 32;
  localparam int NF  = 5;
  localparam int BD  = 4;
  localparam int CW  = 16;
  localparam int WCW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [FW*NF-1:0]  pe_packet_din;
  logic              pe_packet_valid;
  logic              pe_packet_ready;
  logic [FW-1:0]     channel_dout;
  logic              channel_valid_dout;
  logic              channel_credit_din = 1'b0;
  logic [CW-1:0]     packet_count;
  logic              credit_error;

  logic [FW*NF-1:0]  wrap_din;
  logic              wrap_valid;
  logic              wrap_ready;
  logic [FW-1:0]     wrap_dout;
  logic              wrap_vout;
  logic              wrap_credit;
  logic [WCW-1:0]    wrap_count;
  logic              wrap_err;

  pe_packet_injector u_dut (
    .clk                (clk),
    .reset              (reset),
    .pe_packet_din      (pe_packet_din),
    .pe_packet_valid    (pe_packet_valid),
    .pe_packet_ready    (pe_packet_ready),
    .channel_dout       (channel_dout),
    .channel_valid_dout (channel_valid_dout),
    .channel_credit_din (channel_credit_din),
    .packet_count       (packet_count),
    .credit_error       (credit_error)
  );

  // Narrow-counter instance so the count wrap is reachable in a short run.
  pe_packet_injector #(.COUNT_WIDTH(WCW)) u_dut_wrap (
    .clk                (clk),
    .reset              (reset),
    .pe_packet_din      (wrap_din),
    .pe_packet_valid    (wrap_valid),
    .pe_packet_ready    (wrap_ready),
    .channel_dout       (wrap_dout),
    .channel_valid_dout (wrap_vout),
    .channel_credit_din (wrap_credit),
    .packet_count       (wrap_count),
    .credit_error       (wrap_err)
  );

  // Router frees each slot the moment a flit lands.
  assign wrap_credit = wrap_vout;

  always #5 clk = ~clk;

  typedef enum {CR_HOLD, CR_IMM, CR_RAND} credit_mode_e;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [FW-1:0] sb_q[$];
  credit_mode_e  mode          = CR_HOLD;
  int            occupancy     = 0;
  int            flits_seen    = 0;
  int            extra_credits = 0;
  int            cyc           = 0;
  int            last_valid_cyc = -1;
  int            max_gap       = 0;
  logic [CW-1:0] model_count   = '0;
  int            wrap_acc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: header gets tag 2'b10 in its top two bits, everything else verbatim.
  task automatic push_expected(input logic [FW*NF-1:0] pkt);
    logic [FW-1:0] hdr;
    hdr = pkt[FW-1:0];
    sb_q.push_back({2'b10, hdr[FW-3:0]});
    for (int k = 1; k < NF; k++) sb_q.push_back(pkt[k*FW +: FW]);
  endtask

  function automatic logic [FW*NF-1:0] rand_packet();
    logic [FW*NF-1:0] p;
    for (int k = 0; k < NF; k++) p[k*FW +: FW] = $urandom;
    return p;
  endfunction

  // Router model and channel monitor.
  always @(negedge clk) begin
    logic          give;
    logic [FW-1:0] exp_flit;
    cyc++;
    give = 1'b0;
    if (!reset) begin
      if (channel_valid_dout) begin
        flits_seen++;
        if (last_valid_cyc >= 0 && (cyc - last_valid_cyc) > max_gap) max_gap = cyc - last_valid_cyc;
        last_valid_cyc = cyc;
        if (sb_q.size() == 0) begin
          check("flit_expected", 64'(sb_q.size()), 64'd1);
        end else begin
          exp_flit = sb_q.pop_front();
          check("flit", 64'(channel_dout), 64'(exp_flit));
        end
        occupancy++;
        check("buffer_no_overflow", 64'(occupancy <= BD), 64'd1);
      end
      if (extra_credits > 0) begin
        give = 1'b1;
        extra_credits--;
      end else if (occupancy > 0) begin
        case (mode)
          CR_IMM:  give = 1'b1;
          CR_RAND: give = 1'($urandom_range(1, 0));
          default: give = 1'b0;
        endcase
      end
      if (give && occupancy > 0) occupancy--;
    end
    channel_credit_din = give;
  end

  task automatic send_packet(input logic [FW*NF-1:0] pkt, input int idle);
    int budget = 0;
    repeat (idle) begin
      @(negedge clk);
      pe_packet_valid = 1'b0;
    end
    @(negedge clk);
    while (!pe_packet_ready && budget < 500) begin
      pe_packet_valid = 1'b0;
      budget++;
      @(negedge clk);
    end
    if (budget >= 500) begin
      check("accept_wait", 64'(pe_packet_ready), 64'd1);
    end else begin
      pe_packet_din   = pkt;
      pe_packet_valid = 1'b1;
      push_expected(pkt);
      model_count++;
    end
  endtask

  task automatic drain();
    int budget = 0;
    @(negedge clk);
    pe_packet_valid = 1'b0;
    pe_packet_din   = rand_packet();
    while ((sb_q.size() != 0 || !pe_packet_ready || occupancy != 0) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 2000) check("drain_wait", 64'(sb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wrap_run(input int target);
    int budget = 0;
    while (wrap_acc < target && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (wrap_ready && wrap_acc < target) begin
        wrap_valid = 1'b1;
        wrap_acc++;
      end else begin
        wrap_valid = 1'b0;
      end
    end
    @(negedge clk);
    wrap_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("wrap_count", 64'(wrap_count), 64'(wrap_acc % (1 << WCW)));
  endtask

  initial begin
    int               base;
    int               budget;
    logic [FW*NF-1:0] pkt;

    reset           = 1'b1;
    pe_packet_valid = 1'b0;
    pe_packet_din   = '0;
    wrap_valid      = 1'b0;
    wrap_din        = rand_packet();
    settle(3);
    reset = 1'b0;
    #1;
    check("rst_ready", 64'(pe_packet_ready), 64'd1);
    check("rst_valid", 64'(channel_valid_dout), 64'd0);
    check("rst_dout", 64'(channel_dout), 64'd0);
    check("rst_count", 64'(packet_count), 64'd0);
    check("rst_credit_error", 64'(credit_error), 64'd0);

    // No credits returned: four flits, then stall until a single credit arrives.
    mode = CR_HOLD;
    base = flits_seen;
    pkt  = rand_packet();
    pkt[FW-1:0] = {2'b00, 3'd2, 3'd4, 24'h12_3456};
    send_packet(pkt, 0);
    settle(20);
    check("nocredit_flits", 64'(flits_seen - base), 64'd4);
    check("nocredit_valid_low", 64'(channel_valid_dout), 64'd0);
    check("nocredit_ready_low", 64'(pe_packet_ready), 64'd0);
    extra_credits = 1;
    @(negedge clk);
    settle(1);
    check("credit_to_send_cycle1", 64'(channel_valid_dout), 64'd0);
    settle(1);
    check("credit_to_send_cycle2", 64'(channel_valid_dout), 64'd1);
    mode = CR_IMM;
    drain();
    check("count_after_first", 64'(packet_count), 64'(model_count));

    // Surplus credit while full raises the sticky error and does not add a slot.
    settle(1);
    extra_credits = 1;
    settle(4);
    check("credit_error_set", 64'(credit_error), 64'd1);
    mode = CR_HOLD;
    base = flits_seen;
    send_packet(rand_packet(), 0);
    settle(20);
    check("overflow_no_extra_slot", 64'(flits_seen - base), 64'd4);
    check("credit_error_sticky", 64'(credit_error), 64'd1);
    mode = CR_IMM;
    drain();
    check("count_after_error", 64'(packet_count), 64'(model_count));

    // Reset in the middle of a packet.
    base = flits_seen;
    send_packet(rand_packet(), 0);
    budget = 0;
    do begin
      settle(1);
      budget++;
    end while ((flits_seen - base) < 2 && budget < 100);
    check("midpkt_reached_flit2", 64'(flits_seen - base >= 2), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_valid", 64'(channel_valid_dout), 64'd0);
    check("abort_ready", 64'(pe_packet_ready), 64'd1);
    check("abort_count", 64'(packet_count), 64'd0);
    check("abort_credit_error", 64'(credit_error), 64'd0);
    sb_q.delete();
    occupancy   = 0;
    model_count = '0;
    pe_packet_valid = 1'b0;
    settle(2);
    reset = 1'b0;
    mode  = CR_HOLD;
    base  = flits_seen;
    send_packet(rand_packet(), 1);
    settle(20);
    check("post_reset_full_credits", 64'(flits_seen - base), 64'd4);
    mode = CR_IMM;
    drain();
    check("count_after_abort", 64'(packet_count), 64'(model_count));

    // Randomised traffic with random credit return.
    mode = CR_RAND;
    for (int i = 0; i < 25; i++) send_packet(rand_packet(), int'($urandom_range(3, 0)));
    drain();
    check("count_after_random", 64'(packet_count), 64'(model_count));

    // Back-to-back burst with credits returned alongside each send.
    mode = CR_IMM;
    settle(1);
    last_valid_cyc = -1;
    max_gap        = 0;
    base           = flits_seen;
    for (int i = 0; i < 20; i++) send_packet(rand_packet(), 0);
    drain();
    check("burst_flits", 64'(flits_seen - base), 64'd100);
    check("burst_max_gap", 64'(max_gap), 64'd2);
    check("count_after_burst", 64'(packet_count), 64'(model_count));
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    // Counter wrap on the narrow instance.
    wrap_run(1 << WCW);
    wrap_run((1 << WCW) + 3);
    check("wrap_credit_error", 64'(wrap_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
